// File: rtl/conv_config_receiver_pkg.sv
// Shared constants for the conv config port receiver: byte addresses of each
// configuration field inside the byte-addressed config space, the size of that
// space, and the receiver FSM state encoding.
package conv_config_receiver_pkg;

    localparam int CFG_NUM_BYTES = 34;

    localparam int ADR_WEIGHT_MAX         = 0;
    localparam int ADR_IFMAP_MAX          = 2;
    localparam int ADR_OFMAP_MAX          = 4;
    localparam int ADR_OX0                = 6;
    localparam int ADR_OY0                = 8;
    localparam int ADR_FX                 = 10;
    localparam int ADR_FY                 = 12;
    localparam int ADR_STRIDE             = 14;
    localparam int ADR_IX0                = 16;
    localparam int ADR_IY0                = 18;
    localparam int ADR_IC1                = 20;
    localparam int ADR_OC1                = 22;
    localparam int ADR_IC1_FY_FX_OY0_OX0  = 26;
    localparam int ADR_OY0_OX0            = 30;

    localparam logic [1:0] STATE_LOAD   = 2'd0;
    localparam logic [1:0] STATE_PEND   = 2'd1;
    localparam logic [1:0] STATE_COMMIT = 2'd2;

endpackage

// File: rtl/conv_config_receiver.sv
// Responder end of the conv config port. Byte writes land in a shadow copy of
// the layer configuration; once every byte has been written and the datapath
// is idle, the whole shadow is copied to the cfg_* outputs in a single cycle so
// the address generators never see a mix of old and new fields.
module conv_config_receiver
    import conv_config_receiver_pkg::*;
#(
    parameter int CONFIG_ADDR_WIDTH      = 8,
    parameter int CONFIG_DATA_WIDTH      = 8,
    parameter int WEIGHT_BANK_ADDR_WIDTH = 10,
    parameter int IFMAP_BANK_ADDR_WIDTH  = 10,
    parameter int OFMAP_BANK_ADDR_WIDTH  = 8,
    parameter int COUNTER_WIDTH          = 32
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [CONFIG_ADDR_WIDTH+CONFIG_DATA_WIDTH-1:0] config_data,
    input  logic                                         config_vld,
    output logic                                         config_rdy,
    input  logic                                         layer_busy,
    output logic                                         cfg_vld,
    output logic                                         cfg_commit,
    output logic [WEIGHT_BANK_ADDR_WIDTH-1:0]            cfg_weight_max_adr,
    output logic [IFMAP_BANK_ADDR_WIDTH-1:0]             cfg_ifmap_max_wadr,
    output logic [OFMAP_BANK_ADDR_WIDTH-1:0]             cfg_ofmap_max_adr,
    output logic [IFMAP_BANK_ADDR_WIDTH-1:0]             cfg_ox0,
    output logic [IFMAP_BANK_ADDR_WIDTH-1:0]             cfg_oy0,
    output logic [IFMAP_BANK_ADDR_WIDTH-1:0]             cfg_fx,
    output logic [IFMAP_BANK_ADDR_WIDTH-1:0]             cfg_fy,
    output logic [IFMAP_BANK_ADDR_WIDTH-1:0]             cfg_stride,
    output logic [IFMAP_BANK_ADDR_WIDTH-1:0]             cfg_ix0,
    output logic [IFMAP_BANK_ADDR_WIDTH-1:0]             cfg_iy0,
    output logic [IFMAP_BANK_ADDR_WIDTH-1:0]             cfg_ic1,
    output logic [COUNTER_WIDTH-1:0]                     cfg_oc1,
    output logic [COUNTER_WIDTH-1:0]                     cfg_ic1_fy_fx_oy0_ox0,
    output logic [COUNTER_WIDTH-1:0]                     cfg_oy0_ox0
);

    logic [CONFIG_ADDR_WIDTH-1:0]                      wr_adr;
    logic [CONFIG_DATA_WIDTH-1:0]                      wr_byte;
    logic                                              transfer;
    logic [CFG_NUM_BYTES-1:0][CONFIG_DATA_WIDTH-1:0]   shadow;
    logic [CFG_NUM_BYTES-1:0]                          mask;
    logic [CFG_NUM_BYTES-1:0]                          byte_hit;
    logic [CFG_NUM_BYTES-1:0]                          mask_next;
    logic [1:0]                                        state;
    logic [1:0]                                        state_next;
    logic                                              commit_go;

    assign wr_adr   = config_data[CONFIG_ADDR_WIDTH+CONFIG_DATA_WIDTH-1 -: CONFIG_ADDR_WIDTH];
    assign wr_byte  = config_data[CONFIG_DATA_WIDTH-1:0];
    assign transfer = config_vld && config_rdy;

    // Decode the write address to a one-hot byte select; addresses past the
    // config space match nothing, so they are accepted but have no effect.
    always_comb begin
        byte_hit = '0;
        for (int i = 0; i < CFG_NUM_BYTES; i++) begin
            if (transfer && (wr_adr == CONFIG_ADDR_WIDTH'(i))) begin
                byte_hit[i] = 1'b1;
            end
        end
        mask_next = mask | byte_hit;
    end

    // Next-state logic; the mask test uses mask_next so the write that fills
    // the last byte moves the FSM to PEND on that same edge.
    always_comb begin
        state_next = state;
        case (state)
            STATE_LOAD:   if (&mask_next)  state_next = STATE_PEND;
            STATE_PEND:   if (!layer_busy) state_next = STATE_COMMIT;
            STATE_COMMIT: state_next = STATE_LOAD;
            default:      state_next = STATE_LOAD;
        endcase
    end

    assign commit_go = (state == STATE_PEND) && (state_next == STATE_COMMIT);

    // State register plus registered handshake/pulse outputs derived from the
    // upcoming state, so config_rdy stays low through reset and rises one clock later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= STATE_LOAD;
            config_rdy <= 1'b0;
            cfg_commit <= 1'b0;
            cfg_vld    <= 1'b0;
        end else begin
            state      <= state_next;
            config_rdy <= (state_next == STATE_LOAD);
            cfg_commit <= (state_next == STATE_COMMIT);
            if (commit_go) begin
                cfg_vld <= 1'b1;
            end
        end
    end

    // Shadow bytes and the arrival mask; the mask is emptied when the shadow is
    // committed so the next layer must rewrite every byte before committing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            mask   <= '0;
        end else begin
            for (int i = 0; i < CFG_NUM_BYTES; i++) begin
                if (byte_hit[i]) begin
                    shadow[i] <= wr_byte;
                end
            end
            if (commit_go) begin
                mask <= '0;
            end else begin
                mask <= mask_next;
            end
        end
    end

    // Copy every field from the shadow in one edge; the size casts drop the
    // upper bits of fields narrower than the bytes that carry them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_weight_max_adr    <= '0;
            cfg_ifmap_max_wadr    <= '0;
            cfg_ofmap_max_adr     <= '0;
            cfg_ox0               <= '0;
            cfg_oy0               <= '0;
            cfg_fx                <= '0;
            cfg_fy                <= '0;
            cfg_stride            <= '0;
            cfg_ix0               <= '0;
            cfg_iy0               <= '0;
            cfg_ic1               <= '0;
            cfg_oc1               <= '0;
            cfg_ic1_fy_fx_oy0_ox0 <= '0;
            cfg_oy0_ox0           <= '0;
        end else if (commit_go) begin
            cfg_weight_max_adr    <= WEIGHT_BANK_ADDR_WIDTH'(shadow[ADR_WEIGHT_MAX +: 2]);
            cfg_ifmap_max_wadr    <= IFMAP_BANK_ADDR_WIDTH'(shadow[ADR_IFMAP_MAX +: 2]);
            cfg_ofmap_max_adr     <= OFMAP_BANK_ADDR_WIDTH'(shadow[ADR_OFMAP_MAX +: 2]);
            cfg_ox0               <= IFMAP_BANK_ADDR_WIDTH'(shadow[ADR_OX0 +: 2]);
            cfg_oy0               <= IFMAP_BANK_ADDR_WIDTH'(shadow[ADR_OY0 +: 2]);
            cfg_fx                <= IFMAP_BANK_ADDR_WIDTH'(shadow[ADR_FX +: 2]);
            cfg_fy                <= IFMAP_BANK_ADDR_WIDTH'(shadow[ADR_FY +: 2]);
            cfg_stride            <= IFMAP_BANK_ADDR_WIDTH'(shadow[ADR_STRIDE +: 2]);
            cfg_ix0               <= IFMAP_BANK_ADDR_WIDTH'(shadow[ADR_IX0 +: 2]);
            cfg_iy0               <= IFMAP_BANK_ADDR_WIDTH'(shadow[ADR_IY0 +: 2]);
            cfg_ic1               <= IFMAP_BANK_ADDR_WIDTH'(shadow[ADR_IC1 +: 2]);
            cfg_oc1               <= COUNTER_WIDTH'(shadow[ADR_OC1 +: 4]);
            cfg_ic1_fy_fx_oy0_ox0 <= COUNTER_WIDTH'(shadow[ADR_IC1_FY_FX_OY0_OX0 +: 4]);
            cfg_oy0_ox0           <= COUNTER_WIDTH'(shadow[ADR_OY0_OX0 +: 4]);
        end
    end

endmodule

// File: tb/tb_conv_config_receiver.sv
// Self-checking bench for conv_config_receiver: drives byte writes (directed
// and randomized) and compares against a byte-array model of the config space.
module tb_conv_config_receiver;

    localparam int NB = 34;
    localparam int NF = 14;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] config_data;
    logic        config_vld;
    logic        config_rdy;
    logic        layer_busy;
    logic        cfg_vld;
    logic        cfg_commit;
    logic [9:0]  cfg_weight_max_adr;
    logic [9:0]  cfg_ifmap_max_wadr;
    logic [7:0]  cfg_ofmap_max_adr;
    logic [9:0]  cfg_ox0;
    logic [9:0]  cfg_oy0;
    logic [9:0]  cfg_fx;
    logic [9:0]  cfg_fy;
    logic [9:0]  cfg_stride;
    logic [9:0]  cfg_ix0;
    logic [9:0]  cfg_iy0;
    logic [9:0]  cfg_ic1;
    logic [31:0] cfg_oc1;
    logic [31:0] cfg_ic1_fy_fx_oy0_ox0;
    logic [31:0] cfg_oy0_ox0;

    conv_config_receiver dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .config_data           (config_data),
        .config_vld            (config_vld),
        .config_rdy            (config_rdy),
        .layer_busy            (layer_busy),
        .cfg_vld               (cfg_vld),
        .cfg_commit            (cfg_commit),
        .cfg_weight_max_adr    (cfg_weight_max_adr),
        .cfg_ifmap_max_wadr    (cfg_ifmap_max_wadr),
        .cfg_ofmap_max_adr     (cfg_ofmap_max_adr),
        .cfg_ox0               (cfg_ox0),
        .cfg_oy0               (cfg_oy0),
        .cfg_fx                (cfg_fx),
        .cfg_fy                (cfg_fy),
        .cfg_stride            (cfg_stride),
        .cfg_ix0               (cfg_ix0),
        .cfg_iy0               (cfg_iy0),
        .cfg_ic1               (cfg_ic1),
        .cfg_oc1               (cfg_oc1),
        .cfg_ic1_fy_fx_oy0_ox0 (cfg_ic1_fy_fx_oy0_ox0),
        .cfg_oy0_ox0           (cfg_oy0_ox0)
    );

    // 100 MHz free-running clock
    always #5 clk = ~clk;

    // Field layout of the config space: first byte, byte count, field width
    int    fieldBase  [NF] = '{0, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 22, 26, 30};
    int    fieldLen   [NF] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 4, 4, 4};
    int    fieldWidth [NF] = '{10, 10, 8, 10, 10, 10, 10, 10, 10, 10, 10, 32, 32, 32};
    string fieldName  [NF] = '{"weightMax", "ifmapMax", "ofmapMax", "ox0", "oy0", "fx", "fy",
                               "stride", "ix0", "iy0", "ic1", "oc1", "ic1FyFxOy0Ox0", "oy0Ox0"};

    logic [31:0] dutField [NF];
    assign dutField[0]  = 32'(cfg_weight_max_adr);
    assign dutField[1]  = 32'(cfg_ifmap_max_wadr);
    assign dutField[2]  = 32'(cfg_ofmap_max_adr);
    assign dutField[3]  = 32'(cfg_ox0);
    assign dutField[4]  = 32'(cfg_oy0);
    assign dutField[5]  = 32'(cfg_fx);
    assign dutField[6]  = 32'(cfg_fy);
    assign dutField[7]  = 32'(cfg_stride);
    assign dutField[8]  = 32'(cfg_ix0);
    assign dutField[9]  = 32'(cfg_iy0);
    assign dutField[10] = 32'(cfg_ic1);
    assign dutField[11] = cfg_oc1;
    assign dutField[12] = cfg_ic1_fy_fx_oy0_ox0;
    assign dutField[13] = cfg_oy0_ox0;

    // Reference model: bytes written so far, which have arrived, and what the
    // outputs should currently show
    logic [7:0]  modelBytes [NB];
    bit          modelMask  [NB];
    logic [31:0] modelCfg   [NF];
    bit          modelVld;

    int checkCount = 0;
    int failCount  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelField(input int f);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < fieldLen[f]; i++) begin
            v = v | (64'(modelBytes[fieldBase[f] + i]) << (8 * i));
        end
        v = v & ((64'd1 << fieldWidth[f]) - 64'd1);
        return v[31:0];
    endfunction

    task automatic modelClear();
        for (int i = 0; i < NB; i++) begin
            modelBytes[i] = 8'h00;
            modelMask[i]  = 1'b0;
        end
        for (int f = 0; f < NF; f++) modelCfg[f] = 32'h0;
        modelVld = 1'b0;
    endtask

    task automatic checkFields(input string tag);
        for (int f = 0; f < NF; f++) begin
            checkOutput($sformatf("%s.%s", tag, fieldName[f]), dutField[f], modelCfg[f]);
        end
        checkOutput($sformatf("%s.cfgVld", tag), 32'(cfg_vld), 32'(modelVld));
    endtask

    // One write on the config port; waits (bounded) for config_rdy, returns
    // just after the accepting edge
    task automatic applyStimulus(input logic [7:0] adr, input logic [7:0] data);
        int waited;
        waited = 0;
        @(negedge clk);
        config_data = {adr, data};
        config_vld  = 1'b1;
        while (!config_rdy && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!config_rdy) begin
            checkOutput("rdyTimeout", 32'(config_rdy), 32'd1);
            config_vld = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        config_vld = 1'b0;
        if (adr < 8'(NB)) begin
            modelBytes[adr] = data;
            modelMask[adr]  = 1'b1;
        end
    endtask

    // Called right after the completing write: checks PEND while layer_busy is
    // held for busyCycles, then the commit pulse and the return to loading
    task automatic expectCommit(input string tag, input int busyCycles);
        @(negedge clk);
        checkOutput({tag, ".pendRdy"}, 32'(config_rdy), 32'd0);
        checkOutput({tag, ".pendCommit"}, 32'(cfg_commit), 32'd0);
        checkOutput({tag, ".pendVld"}, 32'(cfg_vld), 32'(modelVld));
        for (int i = 0; i < busyCycles; i++) begin
            @(negedge clk);
            checkOutput({tag, ".busyRdy"}, 32'(config_rdy), 32'd0);
            checkOutput({tag, ".busyCommit"}, 32'(cfg_commit), 32'd0);
            if (i == busyCycles - 1) checkFields({tag, ".busyHold"});
        end
        layer_busy = 1'b0;
        @(negedge clk);
        for (int f = 0; f < NF; f++) modelCfg[f] = modelField(f);
        for (int i = 0; i < NB; i++) modelMask[i] = 1'b0;
        modelVld = 1'b1;
        checkOutput({tag, ".commitPulse"}, 32'(cfg_commit), 32'd1);
        checkOutput({tag, ".commitRdy"}, 32'(config_rdy), 32'd0);
        checkFields({tag, ".commit"});
        @(negedge clk);
        checkOutput({tag, ".pulseEnd"}, 32'(cfg_commit), 32'd0);
        checkOutput({tag, ".rdyBack"}, 32'(config_rdy), 32'd1);
    endtask

    // Confirms nothing commits for a few cycles while the load is incomplete
    task automatic expectIdle(input string tag);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput({tag, ".rdy"}, 32'(config_rdy), 32'd1);
            checkOutput({tag, ".commit"}, 32'(cfg_commit), 32'd0);
            checkOutput({tag, ".vld"}, 32'(cfg_vld), 32'(modelVld));
        end
    endtask

    task automatic doReset(input string tag);
        rst_n = 1'b0;
        #2;
        modelClear();
        checkOutput({tag, ".rdy"}, 32'(config_rdy), 32'd0);
        checkOutput({tag, ".commit"}, 32'(cfg_commit), 32'd0);
        checkFields(tag);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput({tag, ".rdyAtRelease"}, 32'(config_rdy), 32'd0);
        @(negedge clk);
        checkOutput({tag, ".rdyAfterRelease"}, 32'(config_rdy), 32'd1);
    endtask

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] d;
        int order [NB];

        rst_n       = 1'b0;
        config_vld  = 1'b0;
        config_data = 16'h0;
        layer_busy  = 1'b0;
        modelClear();
        #12;
        doReset("reset");

        // In-order load with known OX0, OC1 and saturated weight bytes
        for (int i = 0; i < NB; i++) begin
            d = 8'($urandom);
            if (i == 0 || i == 1) d = 8'hFF;
            if (i == 6) d = 8'h03;
            if (i == 7 || (i >= 23 && i <= 25)) d = 8'h00;
            if (i == 22) d = 8'h01;
            applyStimulus(8'(i), d);
        end
        expectCommit("inOrder", 0);
        checkOutput("inOrder.ox0Const", 32'(cfg_ox0), 32'd3);
        checkOutput("inOrder.oc1Const", cfg_oc1, 32'd1);
        checkOutput("inOrder.weightTrunc", 32'(cfg_weight_max_adr), 32'h3FF);

        // Missing the last byte must not commit
        for (int i = 0; i < NB - 1; i++) applyStimulus(8'(i), 8'($urandom));
        expectIdle("partial");
        applyStimulus(8'(NB - 1), 8'($urandom));
        expectCommit("lastByte", 0);

        // Commit held off by layer_busy
        layer_busy = 1'b1;
        for (int i = 0; i < NB; i++) applyStimulus(8'(i), 8'($urandom));
        expectCommit("busy", 10);

        // Out-of-range addresses and a duplicate write mid-load
        for (int i = 0; i < 16; i++) applyStimulus(8'(i), (i == 7) ? 8'h00 : 8'($urandom));
        applyStimulus(8'd34, 8'hA5);
        applyStimulus(8'd200, 8'h5A);
        applyStimulus(8'd6, 8'h02);
        applyStimulus(8'd6, 8'h05);
        for (int i = 16; i < NB; i++) applyStimulus(8'(i), 8'($urandom));
        expectCommit("dupInvalid", 0);
        checkOutput("dupInvalid.ox0Const", 32'(cfg_ox0), 32'd5);

        // Reset part-way through a load discards the partial shadow and mask
        for (int i = 0; i < 20; i++) applyStimulus(8'(i), 8'($urandom));
        doReset("midReset");
        for (int i = 20; i < NB; i++) applyStimulus(8'(i), 8'($urandom));
        expectIdle("afterReset");
        for (int i = 0; i < 20; i++) applyStimulus(8'(i), 8'($urandom));
        expectCommit("reload", 0);

        // Randomized loads: shuffled order, stray addresses, duplicates, busy
        for (int n = 0; n < 6; n++) begin
            int busy;
            for (int i = 0; i < NB; i++) order[i] = i;
            for (int i = NB - 1; i > 0; i--) begin
                int j;
                int t;
                j = int'($urandom_range(i, 0));
                t = order[i];
                order[i] = order[j];
                order[j] = t;
            end
            busy = int'($urandom_range(5, 0));
            layer_busy = (busy > 0);
            for (int k = 0; k < NB; k++) begin
                if ($urandom_range(5, 0) == 0) applyStimulus(8'($urandom_range(255, 34)), 8'($urandom));
                if (k > 0 && $urandom_range(5, 0) == 0) begin
                    applyStimulus(8'(order[$urandom_range(k - 1, 0)]), 8'($urandom));
                end
                applyStimulus(8'(order[k]), 8'($urandom));
            end
            expectCommit($sformatf("rand%0d", n), busy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
